// File: rtl/program_loader_if.sv
// Loader-side bundle: serial input, load request, RAM write port and load status.
// The loader is the master; the core-side glue (or the bench) is the slave.
interface program_loader_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 4
);
    logic                     i_UART_RX;
    logic                     i_LOAD_START;
    logic                     o_CPU_HOLD;
    logic [ADDRESS_WIDTH-1:0] o_RAM_ADDR;
    logic [DATA_WIDTH-1:0]    o_RAM_DATA;
    logic                     o_RAM_WRITE;
    logic                     o_DONE;
    logic                     o_FRAME_ERROR;
    logic [ADDRESS_WIDTH:0]   o_BYTE_COUNT;

    modport master (
        input  i_UART_RX, i_LOAD_START,
        output o_CPU_HOLD, o_RAM_ADDR, o_RAM_DATA, o_RAM_WRITE,
        output o_DONE, o_FRAME_ERROR, o_BYTE_COUNT
    );

    modport slave (
        output i_UART_RX, i_LOAD_START,
        input  o_CPU_HOLD, o_RAM_ADDR, o_RAM_DATA, o_RAM_WRITE,
        input  o_DONE, o_FRAME_ERROR, o_BYTE_COUNT
    );
endinterface

// File: rtl/program_loader.sv
// UART (8N1) program loader: holds the CPU, receives RAM_LENGTH bytes and writes
// them to RAM addresses 0..RAM_LENGTH-1, then releases the CPU.
//
//  rx state  | meaning
//  RX_IDLE   | waiting for a low level (and for high after a bad stop bit)
//  RX_START  | half-bit wait, confirm start bit is still low
//  RX_DATA   | sampling DATA_WIDTH bits, LSB first, one per bit time
//  RX_STOP   | sampling stop bit; 1 -> byte_valid, 0 -> frame error
//
//  ld state  | meaning
//  LD_IDLE   | CPU free, no load in progress
//  LD_LOADING| CPU held, received bytes are written to RAM
//  LD_DONE   | full image written, CPU free, counters held
module program_loader #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 4,
    parameter int RAM_LENGTH    = 16,
    parameter int CLKS_PER_BIT  = 434
) (
    input logic               i_SYS_CLOCK,
    input logic               i_CLEAR,
    program_loader_if.master  bus
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_LAST = ADDRESS_WIDTH'(RAM_LENGTH - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {LD_IDLE, LD_LOADING, LD_DONE} ld_state_t;

    rx_state_t rx_state_q, rx_state_d;
    ld_state_t ld_state_q, ld_state_d;

    logic                  rx_sync1, rx_sync2;
    logic [CW-1:0]         clk_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] rx_shift;
    logic                  rx_wait_high;
    logic                  byte_valid;
    logic                  frame_err_pulse;
    logic                  tick;

    logic [ADDRESS_WIDTH-1:0] addr;
    logic [ADDRESS_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0]    ram_data;
    logic                     ram_write;
    logic                     frame_error;
    logic [ADDRESS_WIDTH:0]   byte_count;

    assign tick = (clk_cnt == '0);

    always_comb begin
        rx_state_d = rx_state_q;
        case (rx_state_q)
            RX_IDLE:  if (!rx_sync2 && !rx_wait_high) rx_state_d = RX_START;
            RX_START: if (tick) rx_state_d = rx_sync2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (tick && bit_cnt == '0) rx_state_d = RX_STOP;
            RX_STOP:  if (tick) rx_state_d = RX_IDLE;
            default:  rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge i_SYS_CLOCK) begin
        if (i_CLEAR) begin
            rx_sync1        <= 1'b1;
            rx_sync2        <= 1'b1;
            rx_state_q      <= RX_IDLE;
            clk_cnt         <= '0;
            bit_cnt         <= '0;
            rx_shift        <= '0;
            rx_wait_high    <= 1'b0;
            byte_valid      <= 1'b0;
            frame_err_pulse <= 1'b0;
        end else begin
            rx_sync1        <= bus.i_UART_RX;
            rx_sync2        <= rx_sync1;
            rx_state_q      <= rx_state_d;
            byte_valid      <= 1'b0;
            frame_err_pulse <= 1'b0;
            if (rx_sync2) rx_wait_high <= 1'b0;
            if (rx_state_q == RX_IDLE) begin
                clk_cnt <= CNT_HALF;
                bit_cnt <= BIT_LAST;
            end else begin
                clk_cnt <= tick ? CNT_FULL : clk_cnt - 1'b1;
            end
            if (rx_state_q == RX_DATA && tick) begin
                rx_shift <= {rx_sync2, rx_shift[DATA_WIDTH-1:1]};
                bit_cnt  <= bit_cnt - 1'b1;
            end
            // A low stop bit may be a break; re-arm only once the line returns high.
            if (rx_state_q == RX_STOP && tick) begin
                if (rx_sync2) begin
                    byte_valid <= 1'b1;
                end else begin
                    frame_err_pulse <= 1'b1;
                    rx_wait_high    <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        ld_state_d = ld_state_q;
        case (ld_state_q)
            LD_IDLE:    if (bus.i_LOAD_START) ld_state_d = LD_LOADING;
            LD_LOADING: if (ram_write && ram_addr == ADDR_LAST) ld_state_d = LD_DONE;
            LD_DONE:    if (bus.i_LOAD_START) ld_state_d = LD_LOADING;
            default:    ld_state_d = LD_IDLE;
        endcase
    end

    always_ff @(posedge i_SYS_CLOCK) begin
        if (i_CLEAR) begin
            ld_state_q  <= LD_IDLE;
            addr        <= '0;
            ram_addr    <= '0;
            ram_data    <= '0;
            ram_write   <= 1'b0;
            frame_error <= 1'b0;
            byte_count  <= '0;
        end else begin
            ld_state_q <= ld_state_d;
            ram_write  <= 1'b0;
            if (ld_state_q != LD_LOADING) begin
                if (bus.i_LOAD_START) begin
                    addr        <= '0;
                    byte_count  <= '0;
                    frame_error <= 1'b0;
                end
            end else begin
                if (byte_valid) begin
                    ram_write <= 1'b1;
                    ram_addr  <= addr;
                    ram_data  <= rx_shift;
                end
                // Counters advance at the end of the write cycle, not when it is issued.
                if (ram_write) begin
                    byte_count <= byte_count + 1'b1;
                    if (addr != ADDR_LAST) addr <= addr + 1'b1;
                end
                if (frame_err_pulse) frame_error <= 1'b1;
            end
        end
    end

    assign bus.o_CPU_HOLD    = (ld_state_q == LD_LOADING);
    assign bus.o_DONE        = (ld_state_q == LD_DONE);
    assign bus.o_RAM_ADDR    = ram_addr;
    assign bus.o_RAM_DATA    = ram_data;
    assign bus.o_RAM_WRITE   = ram_write;
    assign bus.o_FRAME_ERROR = frame_error;
    assign bus.o_BYTE_COUNT  = byte_count;
endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader at 4 clocks per bit: full load, framing error,
// glitch rejection, ignored inputs, reload and mid-load reset.
module tb_program_loader;
    localparam int CPB = 4;

    logic clk = 1'b0;
    logic clr;
    int   checks = 0;
    int   failures = 0;

    program_loader_if bus ();

    program_loader #(
        .DATA_WIDTH(8), .ADDRESS_WIDTH(4), .RAM_LENGTH(16), .CLKS_PER_BIT(CPB)
    ) dut (
        .i_SYS_CLOCK(clk),
        .i_CLEAR    (clr),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    logic [3:0] wr_addr_q[$];
    logic [7:0] wr_data_q[$];
    int   multi_write = 0;
    int   hold_bad = 0;
    logic prev_wr = 1'b0;

    always @(negedge clk) begin
        if (bus.o_RAM_WRITE) begin
            wr_addr_q.push_back(bus.o_RAM_ADDR);
            wr_data_q.push_back(bus.o_RAM_DATA);
            if (prev_wr) multi_write++;
            if (!bus.o_CPU_HOLD) hold_bad++;
        end
        prev_wr = bus.o_RAM_WRITE;
    end

    task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic pulse_start();
        bus.i_LOAD_START = 1'b1;
        tick();
        bus.i_LOAD_START = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        bus.i_UART_RX = 1'b0;
        idle(CPB);
        for (int b = 0; b < 8; b++) begin
            bus.i_UART_RX = d[b];
            idle(CPB);
        end
        bus.i_UART_RX = stop;
        idle(CPB);
        bus.i_UART_RX = 1'b1;
    endtask

    task automatic expect_write(input string tag, input int idx, input logic [3:0] a, input logic [7:0] d);
        check_eq({tag, "_count"}, wr_addr_q.size(), idx + 1);
        if (wr_addr_q.size() > idx) begin
            check_eq({tag, "_addr"}, wr_addr_q[idx], a);
            check_eq({tag, "_data"}, wr_data_q[idx], d);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_hold"}, bus.o_CPU_HOLD, 0);
        check_eq({tag, "_done"}, bus.o_DONE, 0);
        check_eq({tag, "_ferr"}, bus.o_FRAME_ERROR, 0);
        check_eq({tag, "_cnt"},  bus.o_BYTE_COUNT, 0);
        check_eq({tag, "_addr"}, bus.o_RAM_ADDR, 0);
        check_eq({tag, "_data"}, bus.o_RAM_DATA, 0);
        check_eq({tag, "_wr"},   bus.o_RAM_WRITE, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clr = 1'b1;
        bus.i_UART_RX = 1'b1;
        bus.i_LOAD_START = 1'b0;
        idle(3);
        clr = 1'b0;
        check_all_zero("reset");

        // Byte while IDLE is ignored.
        idle(2);
        send_byte(8'h5A, 1'b1);
        idle(8);
        check_eq("idle_no_write", wr_addr_q.size(), 0);

        // Full load, back-to-back frames.
        pulse_start();
        check_eq("load_hold", bus.o_CPU_HOLD, 1);
        check_eq("load_done", bus.o_DONE, 0);
        for (int i = 0; i < 16; i++) send_byte(8'h10 + 8'(i), 1'b1);
        idle(8);
        check_eq("full_count", wr_addr_q.size(), 16);
        for (int i = 0; i < 16 && i < wr_addr_q.size(); i++) begin
            check_eq($sformatf("full_addr%0d", i), wr_addr_q[i], i);
            check_eq($sformatf("full_data%0d", i), wr_data_q[i], 8'h10 + i);
        end
        check_eq("full_done", bus.o_DONE, 1);
        check_eq("full_hold", bus.o_CPU_HOLD, 0);
        check_eq("full_bytes", bus.o_BYTE_COUNT, 16);
        check_eq("full_ferr", bus.o_FRAME_ERROR, 0);
        check_eq("full_addr_hold", bus.o_RAM_ADDR, 15);
        check_eq("full_data_hold", bus.o_RAM_DATA, 8'h1F);

        // Byte while DONE is ignored.
        send_byte(8'h77, 1'b1);
        idle(8);
        check_eq("done_no_write", wr_addr_q.size(), 16);
        check_eq("done_bytes", bus.o_BYTE_COUNT, 16);

        // Reload.
        pulse_start();
        check_eq("reload_done", bus.o_DONE, 0);
        check_eq("reload_hold", bus.o_CPU_HOLD, 1);
        check_eq("reload_bytes", bus.o_BYTE_COUNT, 0);
        send_byte(8'hE1, 1'b1);
        idle(8);
        expect_write("reload_e1", 16, 4'd0, 8'hE1);

        // One-cycle glitch is rejected.
        bus.i_UART_RX = 1'b0;
        tick();
        bus.i_UART_RX = 1'b1;
        idle(20);
        check_eq("glitch_no_write", wr_addr_q.size(), 17);
        check_eq("glitch_ferr", bus.o_FRAME_ERROR, 0);
        send_byte(8'h3C, 1'b1);
        idle(8);
        expect_write("glitch_3c", 17, 4'd1, 8'h3C);

        // Framing error: bad byte dropped, next byte goes to the next address.
        send_byte(8'h55, 1'b0);
        idle(2 * CPB);
        check_eq("ferr_no_write", wr_addr_q.size(), 18);
        check_eq("ferr_flag", bus.o_FRAME_ERROR, 1);
        check_eq("ferr_bytes", bus.o_BYTE_COUNT, 2);
        send_byte(8'hAA, 1'b1);
        idle(8);
        expect_write("ferr_aa", 18, 4'd2, 8'hAA);
        check_eq("ferr_bytes_after", bus.o_BYTE_COUNT, 3);
        check_eq("ferr_sticky", bus.o_FRAME_ERROR, 1);

        // Load request while LOADING at count 7 is ignored.
        for (int i = 0; i < 4; i++) send_byte(8'h40 + 8'(i), 1'b1);
        idle(8);
        check_eq("mid_bytes", bus.o_BYTE_COUNT, 7);
        pulse_start();
        check_eq("mid_start_bytes", bus.o_BYTE_COUNT, 7);
        check_eq("mid_start_hold", bus.o_CPU_HOLD, 1);
        send_byte(8'h99, 1'b1);
        idle(8);
        expect_write("mid_99", 23, 4'd7, 8'h99);
        check_eq("mid_bytes_after", bus.o_BYTE_COUNT, 8);

        // Reset mid-load.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check_all_zero("midrst");
        send_byte(8'h66, 1'b1);
        idle(8);
        check_eq("midrst_no_write", wr_addr_q.size(), 24);
        check_eq("midrst_hold", bus.o_CPU_HOLD, 0);

        // Clear wins over a simultaneous load request.
        clr = 1'b1;
        bus.i_LOAD_START = 1'b1;
        tick();
        clr = 1'b0;
        bus.i_LOAD_START = 1'b0;
        check_eq("clr_wins_hold", bus.o_CPU_HOLD, 0);
        tick();
        check_eq("clr_wins_hold2", bus.o_CPU_HOLD, 0);

        check_eq("wr_single_cycle", multi_write, 0);
        check_eq("wr_under_hold", hold_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
UART-fed program loader sitting directly upstream of the CPU core's RAM. On request it holds the CPU in clear, receives RAM_LENGTH bytes over an 8N1 serial line and writes them into RAM addresses 0..RAM_LENGTH-1 in order. It then releases the CPU. The top level muxes o_RAM_ADDR/o_RAM_DATA/o_RAM_WRITE onto the RAM port and ORs o_CPU_HOLD into the core's CLEAR while o_CPU_HOLD=1.

Parameters:
DATA_WIDTH, 8, byte width written to RAM; the UART frame carries exactly DATA_WIDTH data bits, LSB first.
ADDRESS_WIDTH, 4, RAM address width.
RAM_LENGTH, 16, number of bytes per load; must be ≤ 2^ADDRESS_WIDTH.
CLKS_PER_BIT, 434, i_SYS_CLOCK cycles per serial bit; minimum 4.

Ports:
i_SYS_CLOCK  in  1  system clock; all logic on its rising edge.
i_CLEAR  in  1  synchronous active-high reset.
i_UART_RX  in  1  asynchronous serial input; idles high.
i_LOAD_START  in  1  single-cycle pulse that requests a new load.
o_CPU_HOLD  out  1  high while loading; holds the CPU in clear and selects the loader onto RAM.
o_RAM_ADDR  out  ADDRESS_WIDTH  RAM write address.
o_RAM_DATA  out  DATA_WIDTH  RAM write data.
o_RAM_WRITE  out  1  single-cycle RAM write strobe.
o_DONE  out  1  high after a complete load, until the next load request.
o_FRAME_ERROR  out  1  sticky flag: bad stop bit seen during the current load.
o_BYTE_COUNT  out  ADDRESS_WIDTH+1  number of bytes written in the current load.

Behaviour:
- Reset: i_CLEAR is synchronous and active-high. All outputs are 0, the loader FSM is IDLE, the receiver is idle, and the address counter is 0. Reset mid-load aborts the load. RAM keeps the bytes already written. The CPU is released in the cycle after reset.
- RX synchroniser: two flops on i_UART_RX, reset value 1. The receiver sees only the synchronised signal. This adds 2 cycles of input latency.
- Receiver FSM: RX_IDLE → RX_START → RX_DATA → RX_STOP → RX_IDLE.
  - RX_IDLE: a low level on the synchronised line starts a bit counter and moves to RX_START.
  - RX_START: resample at CLKS_PER_BIT/2 (integer division). If the line is high, the start was a glitch; return to RX_IDLE and deliver no byte.
  - RX_DATA: sample every CLKS_PER_BIT cycles, DATA_WIDTH samples, shifted in LSB first.
  - RX_STOP: sample once, CLKS_PER_BIT cycles after the last data sample.
    - Stop bit = 1: a one-cycle internal byte_valid pulses in the next cycle.
    - Stop bit = 0: the byte is discarded and o_FRAME_ERROR is set if the loader is LOADING.
    - Either way, return to RX_IDLE and wait for the line to go high before accepting a new start bit. This prevents re-triggering on a break.
  - The receiver runs in every loader state. byte_valid is ignored unless the loader is LOADING.
- Loader FSM: IDLE, LOADING, DONE.
  - IDLE: o_CPU_HOLD=0, o_DONE=0. i_LOAD_START → LOADING. In the same edge: address counter, o_BYTE_COUNT and o_FRAME_ERROR clear to 0, and o_CPU_HOLD goes to 1.
  - LOADING, on byte_valid, in the following cycle:
    - o_RAM_WRITE=1 for exactly one cycle.
    - o_RAM_ADDR = current address and o_RAM_DATA = received byte, both stable in that cycle.
    - The address and o_BYTE_COUNT increment at the end of that cycle.
  - LOADING, after the write with o_RAM_ADDR = RAM_LENGTH-1: go to DONE. o_BYTE_COUNT = RAM_LENGTH. There is no address wrap.
  - LOADING, i_LOAD_START: ignored. It does not restart the load.
  - DONE: o_CPU_HOLD=0, o_DONE=1. o_BYTE_COUNT and o_FRAME_ERROR hold their values. i_LOAD_START → LOADING with the same clears as from IDLE, and o_DONE drops.
- o_RAM_WRITE is never asserted outside LOADING. o_RAM_ADDR and o_RAM_DATA hold their last written values between writes.
- End-to-end latency: byte_valid follows the stop-bit sample by 1 cycle, and the o_RAM_WRITE cycle follows byte_valid by 1 cycle.
- Simultaneous i_CLEAR and i_LOAD_START: i_CLEAR wins.
- Back-to-back frames with no idle gap beyond the stop bit must be received without loss.

Test Plan:
1. Full load: CLKS_PER_BIT=4, RAM_LENGTH=16. Pulse i_LOAD_START, then send bytes 0x10..0x1F back-to-back → 16 single-cycle writes with addr 0..15 and data 0x10..0x1F. Then o_DONE=1, o_CPU_HOLD=0, o_BYTE_COUNT=16, o_FRAME_ERROR=0.
2. Framing error: during a load, send 0x55 with stop bit=0, then 0xAA → no write for 0x55. o_FRAME_ERROR=1. 0xAA is written to the next address. o_BYTE_COUNT advances by 1 only.
3. Glitch rejection: a 1-cycle low pulse on i_UART_RX while LOADING → no byte, no write, no error. A following valid 0x3C is written normally.
4. Reset mid-load: send 5 bytes, then assert i_CLEAR for 1 cycle → in the next cycle all outputs are 0 and the FSM is IDLE. Bytes received afterwards produce no writes until i_LOAD_START.
5. Ignored inputs: bytes sent while IDLE or DONE produce no o_RAM_WRITE. An i_LOAD_START pulse while LOADING at count 7 does not reset the address (the next write goes to addr 7).
6. Reload: from DONE, pulse i_LOAD_START → o_DONE=0, o_CPU_HOLD=1, o_BYTE_COUNT=0. The first new byte 0xE1 is written to addr 0.
